lsu_ctrl: RTL and testbench

Load/store sequencer between the RV32I core's memory stage and the data SRAM port. It accepts one load or store per handshake and derives the word address and byte enables. It drives a req/gnt/rvalid memory interface, aligns and extends load data, and returns one response per request. It replaces the core's direct, same-cycle SRAM access. The core stalls on `req_ready_o` / `rsp_valid_o`.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_load_align.sv | 23 ++
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state encoding and byte-enable helper for the load/store unit
package lsu_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, REQ2, WAIT2, RESP} lsu_state_e;

    // 8-lane mask: [3:0] are the lanes of the first word, [7:4] spill into the next word
    function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b00 ? 8'h01 : size == 2'b01 ? 8'h03 : 8'h0F) << off;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts a (possibly two-word) read value down by the byte offset and extends it per funct3
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [63:0] rdata,
    output logic [31:0] data
);

    logic [31:0] sh;

    assign sh = 32'(rdata >> {off, 3'b000});

    // sign/zero extension from the selected byte or half; words pass unchanged
    always_comb begin
        data = funct3 == LB  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == LH  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == LBU ? {24'b0, sh[7:0]} :
               funct3 == LHU ? {16'b0, sh[15:0]} : sh;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the core memory stage and a req/gnt/rvalid SRAM port.
// Optional feature: define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two aligned ones;
// without it misaligned accesses return an error and never touch memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT = 1'b1;
`else
    localparam logic SPLIT = 1'b0;
`endif

    lsu_state_e            state;
    logic                  we_q;
    logic                  split_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [3:0]            be_hi_q;
    logic [DATA_WIDTH-1:0] wdata_hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic [7:0]            be_in;
    logic [63:0]           wsh_in;
    logic [63:0]           rword;
    logic                  legal;
    logic                  misal;
    logic                  accept;

    assign be_in  = be_gen(req_funct3_i[1:0], req_addr_i[1:0]);
    assign wsh_in = {32'b0, req_wdata_i} << {req_addr_i[1:0], 3'b000};
    assign legal  = req_we_i ? req_funct3_i inside {SB, SH, SW}
                             : req_funct3_i inside {LB, LH, LW, LBU, LHU};
    assign misal  = (req_funct3_i[1:0] == 2'b01 && req_addr_i[1:0] == 2'b11) ||
                    (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
    assign accept = req_valid_i && req_ready_o;
    assign rword  = state == WAIT2 ? {mem_rdata_i, lo_q} : {32'b0, mem_rdata_i};

    lsu_load_align u_align (
        .funct3 (f3_q),
        .off    (off_q),
        .rdata  (rword),
        .data   (load_data)
    );

    // request sequencing with all interface outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            waddr_q     <= '0;
            be_hi_q     <= '0;
            wdata_hi_q  <= '0;
            lo_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_o <= 1'b0;
                        we_q        <= req_we_i;
                        f3_q        <= req_funct3_i;
                        off_q       <= req_addr_i[1:0];
                        waddr_q     <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        be_hi_q     <= be_in[7:4];
                        wdata_hi_q  <= wsh_in[63:32];
                        split_q     <= misal && SPLIT;
                        if (!legal || (misal && !SPLIT)) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            state       <= REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_be_o    <= be_in[3:0];
                            mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_o <= wsh_in[31:0];
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                REQ, REQ2: begin
                    if (mem_gnt_i) begin
                        state       <= state == REQ ? WAIT : WAIT2;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= '0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        if (split_q) begin
                            state       <= REQ2;
                            lo_q        <= mem_rdata_i;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= we_q;
                            mem_be_o    <= be_hi_q;
                            mem_addr_o  <= waddr_q + ADDR_WIDTH'(4);
                            mem_wdata_o <= wdata_hi_q;
                        end else begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= we_q ? '0 : load_data;
                        end
                    end
                end
                WAIT2: begin
                    if (mem_rvalid_i) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= we_q ? '0 : load_data;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                    rsp_data_o  <= '0;
                    rsp_err_o   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector bench for lsu_ctrl with hand-computed expectations
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t tv [12];
    vec_t v;

    lsu_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        tick();
        req_valid_i  = 1'b0;
    endtask

    task automatic run_vec(input vec_t x, input int gd, input int rd);
        chk("ready_before", req_ready_o, 1);
        issue(x.we, x.f3, x.addr, x.wdata);
        if (x.err) begin
            chk("err_valid", rsp_valid_o, 1);
            chk("err_flag", rsp_err_o, 1);
            chk("err_data", rsp_data_o, 0);
            chk("err_no_memreq", mem_req_o, 0);
            chk("err_ready", req_ready_o, 0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                chk("mem_req", mem_req_o, 1);
                chk("mem_we", mem_we_o, x.we);
                chk("mem_be", mem_be_o, x.be);
                chk("mem_addr", mem_addr_o, x.maddr);
                chk("mem_wdata", mem_wdata_o, x.mwdata);
                chk("ready_req", req_ready_o, 0);
                chk("rsp_req", rsp_valid_o, 0);
                mem_gnt_i    = (i == gd);
                mem_rvalid_i = (i != gd);
                mem_rdata_i  = 32'hFFFF_FFFF;
                tick();
            end
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            for (int i = 0; i <= rd; i++) begin
                chk("mem_req_wait", mem_req_o, 0);
                chk("rsp_wait", rsp_valid_o, 0);
                chk("ready_wait", req_ready_o, 0);
                mem_rvalid_i = (i == rd);
                mem_rdata_i  = (i == rd) ? x.rdata : 32'h5A5A_5A5A;
                tick();
            end
            mem_rvalid_i = 1'b0;
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_err", rsp_err_o, 0);
            chk("rsp_data", rsp_data_o, x.data);
        end
        tick();
        chk("rsp_pulse_end", rsp_valid_o, 0);
        chk("rsp_data_zero", rsp_data_o, 0);
        chk("rsp_err_zero", rsp_err_o, 0);
        chk("ready_after", req_ready_o, 1);
    endtask

    task automatic split_access(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] r0,
                                input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] r1,
                                input logic [31:0] data);
        issue(1'b0, f3, addr, 32'h0);
        chk("split_req1", mem_req_o, 1);
        chk("split_addr1", mem_addr_o, a0);
        chk("split_be1", mem_be_o, b0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = r0;
        tick();
        mem_rvalid_i = 1'b0;
        chk("split_req2", mem_req_o, 1);
        chk("split_addr2", mem_addr_o, a1);
        chk("split_be2", mem_be_o, b1);
        chk("split_no_rsp", rsp_valid_o, 0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = r1;
        tick();
        mem_rvalid_i = 1'b0;
        chk("split_rsp", rsp_valid_o, 1);
        chk("split_err", rsp_err_o, 0);
        chk("split_data", rsp_data_o, data);
        tick();
        chk("split_ready", req_ready_o, 1);
    endtask

    initial begin
        tv[0]  = '{1'b0, LB,   32'h103, 32'h0,         32'h80FF_0000, 4'b1000, 32'h100, 32'h0,         1'b0, 32'hFFFF_FF80};
        tv[1]  = '{1'b0, LHU,  32'h102, 32'h0,         32'h8001_1234, 4'b1100, 32'h100, 32'h0,         1'b0, 32'h0000_8001};
        tv[2]  = '{1'b0, LH,   32'h102, 32'h0,         32'h8001_1234, 4'b1100, 32'h100, 32'h0,         1'b0, 32'hFFFF_8001};
        tv[3]  = '{1'b1, SB,   32'h101, 32'h0000_00AB, 32'hDEAD_BEEF, 4'b0010, 32'h100, 32'h0000_AB00, 1'b0, 32'h0};
        tv[4]  = '{1'b0, LW,   32'h200, 32'h0,         32'h1234_5678, 4'b1111, 32'h200, 32'h0,         1'b0, 32'h1234_5678};
        tv[5]  = '{1'b1, SH,   32'h202, 32'h0000_BEEF, 32'h0,         4'b1100, 32'h200, 32'hBEEF_0000, 1'b0, 32'h0};
        tv[6]  = '{1'b1, SW,   32'h300, 32'hCAFE_F00D, 32'h1111_1111, 4'b1111, 32'h300, 32'hCAFE_F00D, 1'b0, 32'h0};
        tv[7]  = '{1'b0, LBU,  32'h001, 32'h0,         32'h0000_9A00, 4'b0010, 32'h000, 32'h0,         1'b0, 32'h0000_009A};
        tv[8]  = '{1'b0, LB,   32'h002, 32'h0,         32'h007F_0000, 4'b0100, 32'h000, 32'h0,         1'b0, 32'h0000_007F};
        tv[9]  = '{1'b0, 3'd3, 32'h100, 32'h0,         32'h0,         4'b0000, 32'h0,   32'h0,         1'b1, 32'h0};
        tv[10] = '{1'b1, 3'd4, 32'h100, 32'h1234_5678, 32'h0,         4'b0000, 32'h0,   32'h0,         1'b1, 32'h0};
        tv[11] = '{1'b1, 3'd5, 32'h104, 32'h1234_5678, 32'h0,         4'b0000, 32'h0,   32'h0,         1'b1, 32'h0};

        repeat (3) tick();
        chk("rst_ready", req_ready_o, 0);
        chk("rst_rsp", rsp_valid_o, 0);
        chk("rst_memreq", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        rst_i = 1'b0;
        tick();
        chk("ready_after_rst", req_ready_o, 1);

        for (int i = 0; i < 12; i++) run_vec(tv[i], 0, 0);

        run_vec(tv[3], 2, 3);
        run_vec(tv[0], 1, 1);

`ifdef LSU_MISALIGN_SPLIT_EN
        split_access(LW, 32'h101, 32'h100, 4'b1110, 32'h4433_2211,
                     32'h104, 4'b0001, 32'h8877_6655, 32'h5544_3322);
        split_access(LH, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 4'b1000, 32'hAB00_0000,
                     32'h0, 4'b0001, 32'h0000_00CD, 32'hFFFF_CDAB);
`else
        v = '{1'b0, LW, 32'h101, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 32'h0};
        run_vec(v, 0, 0);
        v = '{1'b0, LH, 32'h103, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 32'h0};
        run_vec(v, 0, 0);
        v = '{1'b1, SW, 32'h102, 32'hFFFF_FFFF, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 32'h0};
        run_vec(v, 0, 0);
`endif

        issue(1'b0, LW, 32'h200, 32'h0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst_i     = 1'b1;
        tick();
        chk("midrst_ready", req_ready_o, 0);
        chk("midrst_rsp", rsp_valid_o, 0);
        chk("midrst_memreq", mem_req_o, 0);
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_BABE;
        tick();
        mem_rvalid_i = 1'b0;
        chk("stale_rsp", rsp_valid_o, 0);
        chk("stale_data", rsp_data_o, 0);
        chk("stale_err", rsp_err_o, 0);
        chk("stale_memreq", mem_req_o, 0);
        chk("stale_ready", req_ready_o, 1);
        tick();
        chk("stale_rsp2", rsp_valid_o, 0);

        run_vec(tv[4], 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
